adc_scan_sched: RTL and testbench

// Channel scheduler for the LTC2308 ADC interface (adcinterface). Drives its chan input once per
// 16-clock conversion frame: round-robin scan over enabled channels, plus a one-shot

---
 rtl/adc_scan_sched.sv | 176 +++++++++++++++++
 tb/tb_adc_scan_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sched.sv
// Channel scheduler for the LTC2308 adcinterface: each frame it drives one channel, either a
// one-shot request or the next round-robin scan channel, and attributes samples to channels.
// Actions happen only on the last cycle of each frame, and results arrive two frames after issue.
module adc_scan_sched #(
    parameter int FRAME_CYCLES = 16,
    parameter int LAT_FRAMES   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [7:0]  chan_mask,
    input  logic        req,
    input  logic [2:0]  req_chan,
    output logic        done,
    output logic [11:0] done_data,
    output logic [2:0]  adc_chan,
    input  logic [11:0] adc_result,
    output logic        smp_stb,
    output logic [2:0]  smp_chan,
    output logic [11:0] smp_data,
    input  logic [2:0]  rd_chan,
    output logic [11:0] rd_data,
    output logic        rd_valid
);
    localparam int FCW = $clog2(FRAME_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] ch;
        logic       is_req;
    } tag_t;

    state_t            state_q, state_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;
    tag_t              pipe_q [LAT_FRAMES];
    tag_t              pipe_d [LAT_FRAMES];
    logic [11:0]       bank_q [8];
    logic [11:0]       bank_d [8];
    logic [7:0]        valid_q, valid_d;
    logic [2:0]        last_q, last_d;
    logic              infl_q, infl_d;
    logic [2:0]        chan_q, chan_d;
    logic              done_q, done_d;
    logic [11:0]       done_data_q, done_data_d;
    logic              smp_stb_q, smp_stb_d;
    logic [2:0]        smp_chan_q, smp_chan_d;
    logic [11:0]       smp_data_q, smp_data_d;

    logic              tick;
    logic              found;
    logic [2:0]        nxt_ch;
    logic [2:0]        idx;
    tag_t              exit_tag;
    tag_t              new_tag;

    assign tick     = (fcnt_q == FCW'(FRAME_CYCLES - 1));
    assign exit_tag = pipe_q[LAT_FRAMES-1];

    // First enabled channel strictly after the last scanned one; i==8 wraps back onto it.
    always_comb begin
        found  = 1'b0;
        nxt_ch = last_q;
        idx    = last_q;
        for (int i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!found && chan_mask[idx]) begin
                found  = 1'b1;
                nxt_ch = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = tick ? '0 : fcnt_q + 1'b1;
        pipe_d      = pipe_q;
        bank_d      = bank_q;
        valid_d     = valid_q;
        last_d      = last_q;
        infl_d      = done_q ? 1'b0 : infl_q;
        chan_d      = chan_q;
        done_d      = 1'b0;
        done_data_d = done_data_q;
        smp_stb_d   = 1'b0;
        smp_chan_d  = smp_chan_q;
        smp_data_d  = smp_data_q;
        new_tag     = '0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    for (int i = LAT_FRAMES - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
                    pipe_d[0] = '0;
                    if (en) state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    // Abort: drop everything in flight, keep driving the last channel.
                    state_d = IDLE;
                    infl_d  = 1'b0;
                    for (int i = 0; i < LAT_FRAMES; i++) pipe_d[i] = '0;
                end else if (tick) begin
                    if (exit_tag.vld) begin
                        bank_d[exit_tag.ch]  = adc_result;
                        valid_d[exit_tag.ch] = 1'b1;
                        smp_stb_d            = 1'b1;
                        smp_chan_d           = exit_tag.ch;
                        smp_data_d           = adc_result;
                        if (exit_tag.is_req) begin
                            done_d      = 1'b1;
                            done_data_d = adc_result;
                        end
                    end
                    if (req && !infl_q) begin
                        chan_d  = req_chan;
                        new_tag = '{vld: 1'b1, ch: req_chan, is_req: 1'b1};
                        infl_d  = 1'b1;
                    end else if (found) begin
                        chan_d  = nxt_ch;
                        last_d  = nxt_ch;
                        new_tag = '{vld: 1'b1, ch: nxt_ch, is_req: 1'b0};
                    end else begin
                        chan_d = 3'd0;
                    end
                    for (int i = LAT_FRAMES - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
                    pipe_d[0] = new_tag;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            for (int i = 0; i < LAT_FRAMES; i++) pipe_q[i] <= '0;
            for (int i = 0; i < 8; i++) bank_q[i] <= '0;
            valid_q     <= '0;
            last_q      <= 3'd7;
            infl_q      <= 1'b0;
            chan_q      <= '0;
            done_q      <= 1'b0;
            done_data_q <= '0;
            smp_stb_q   <= 1'b0;
            smp_chan_q  <= '0;
            smp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pipe_q      <= pipe_d;
            bank_q      <= bank_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            infl_q      <= infl_d;
            chan_q      <= chan_d;
            done_q      <= done_d;
            done_data_q <= done_data_d;
            smp_stb_q   <= smp_stb_d;
            smp_chan_q  <= smp_chan_d;
            smp_data_q  <= smp_data_d;
        end
    end

    assign adc_chan  = chan_q;
    assign done      = done_q;
    assign done_data = done_data_q;
    assign smp_stb   = smp_stb_q;
    assign smp_chan  = smp_chan_q;
    assign smp_data  = smp_data_q;
    assign rd_data   = bank_q[rd_chan];
    assign rd_valid  = valid_q[rd_chan];
endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed bench for adc_scan_sched with a behavioural adcinterface model that returns 12'h100+ch
// two frames after the channel is driven.
module tb_adc_scan_sched;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  chan_mask = '0;
    logic        req = 1'b0;
    logic [2:0]  req_chan = '0;
    logic        done;
    logic [11:0] done_data;
    logic [2:0]  adc_chan;
    logic [11:0] adc_result;
    logic        smp_stb;
    logic [2:0]  smp_chan;
    logic [11:0] smp_data;
    logic [2:0]  rd_chan = '0;
    logic [11:0] rd_data;
    logic        rd_valid;

    int vectors = 0;
    int miscompares = 0;

    adc_scan_sched dut (
        .clk(clk), .reset_n(reset_n), .en(en), .chan_mask(chan_mask),
        .req(req), .req_chan(req_chan), .done(done), .done_data(done_data),
        .adc_chan(adc_chan), .adc_result(adc_result), .smp_stb(smp_stb),
        .smp_chan(smp_chan), .smp_data(smp_data), .rd_chan(rd_chan),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    // adcinterface model: latches chan at the frame boundary, result lands mid next frame.
    logic [3:0] m_cnt;
    logic [2:0] m_lat;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt      <= '0;
            m_lat      <= '0;
            adc_result <= '0;
        end else begin
            m_cnt <= m_cnt + 4'd1;
            if (m_cnt == 4'd15) m_lat <= adc_chan;
            if (m_cnt == 4'd8)  adc_result <= 12'h100 + {9'd0, m_lat};
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        en        = 1'b0;
        req       = 1'b0;
        req_chan  = '0;
        chan_mask = '0;
        rd_chan   = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] exp;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (adc_chan !== 3'd0 || done !== 1'b0 || smp_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outs: adc_chan=%0d done=%b smp_stb=%b want 0/0/0", adc_chan, done, smp_stb);
        end
        for (int c = 0; c < 8; c++) begin
            rd_chan = 3'(c);
            #1;
            vectors++;
            if (rd_valid !== 1'b0 || rd_data !== 12'h000) begin
                miscompares++;
                $display("FAIL reset_bank ch%0d: valid=%b data=%h want 0/000", c, rd_valid, rd_data);
            end
        end
        // Tick alignment: enable with ch1 only; RUN at edge 15, ch1 issued at edge 31.
        @(negedge clk);
        chan_mask = 8'h02;
        en        = 1'b1;
        reset_n   = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            wait_edges(1);
            exp = (k >= 31) ? 3'd1 : 3'd0;
            vectors++;
            if (adc_chan !== exp) begin
                miscompares++;
                $display("FAIL reset_align edge%0d: adc_chan=%0d want %0d", k, adc_chan, exp);
            end
        end
    endtask

    task automatic test_scan();
        logic [2:0] seq [6];
        seq = '{3'd0, 3'd2, 3'd5, 3'd0, 3'd2, 3'd5};
        apply_reset();
        chan_mask = 8'b0010_0101;
        en        = 1'b1;
        wait_edges(16);
        for (int i = 0; i < 6; i++) begin
            wait_edges(16);
            vectors++;
            if (adc_chan !== seq[i]) begin
                miscompares++;
                $display("FAIL scan_chan frame%0d: adc_chan=%0d want %0d", i, adc_chan, seq[i]);
            end
            vectors++;
            if (i < 2) begin
                if (smp_stb !== 1'b0) begin
                    miscompares++;
                    $display("FAIL scan_early_stb frame%0d: smp_stb=%b want 0", i, smp_stb);
                end
            end else if (smp_stb !== 1'b1 || smp_chan !== seq[i-2] ||
                         smp_data !== (12'h100 + {9'd0, seq[i-2]})) begin
                miscompares++;
                $display("FAIL scan_smp frame%0d: stb=%b ch=%0d data=%h want 1/%0d/%h",
                         i, smp_stb, smp_chan, smp_data, seq[i-2], 12'h100 + {9'd0, seq[i-2]});
            end
        end
        wait_edges(1);
        vectors++;
        if (smp_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_stb_width: smp_stb=%b want 0", smp_stb);
        end
        rd_chan = 3'd2;
        #1;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 12'h102) begin
            miscompares++;
            $display("FAIL scan_bank2: valid=%b data=%h want 1/102", rd_valid, rd_data);
        end
        rd_chan = 3'd1;
        #1;
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_bank1: valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_request();
        apply_reset();
        chan_mask = 8'hFF;
        en        = 1'b1;
        wait_edges(48);
        req      = 1'b1;
        req_chan = 3'd6;
        wait_edges(16);
        vectors++;
        if (adc_chan !== 3'd6) begin
            miscompares++;
            $display("FAIL req_issue: adc_chan=%0d want 6", adc_chan);
        end
        wait_edges(16);
        vectors++;
        if (adc_chan !== 3'd2 || done !== 1'b0 || smp_chan !== 3'd1) begin
            miscompares++;
            $display("FAIL req_resume: adc_chan=%0d done=%b smp_chan=%0d want 2/0/1", adc_chan, done, smp_chan);
        end
        wait_edges(16);
        vectors++;
        if (done !== 1'b1 || done_data !== 12'h106) begin
            miscompares++;
            $display("FAIL req_done: done=%b data=%h want 1/106", done, done_data);
        end
        vectors++;
        if (adc_chan !== 3'd3 || smp_stb !== 1'b1 || smp_chan !== 3'd6 || smp_data !== 12'h106) begin
            miscompares++;
            $display("FAIL req_smp: adc_chan=%0d stb=%b ch=%0d data=%h want 3/1/6/106",
                     adc_chan, smp_stb, smp_chan, smp_data);
        end
        req = 1'b0;
        wait_edges(1);
        rd_chan = 3'd6;
        #1;
        vectors++;
        if (done !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 12'h106) begin
            miscompares++;
            $display("FAIL req_after: done=%b valid=%b data=%h want 0/1/106", done, rd_valid, rd_data);
        end
    endtask

    task automatic test_abort();
        logic seen;
        apply_reset();
        chan_mask = 8'h08;
        en        = 1'b1;
        wait_edges(16);
        req      = 1'b1;
        req_chan = 3'd6;
        wait_edges(16);
        vectors++;
        if (adc_chan !== 3'd6) begin
            miscompares++;
            $display("FAIL abort_issue: adc_chan=%0d want 6", adc_chan);
        end
        wait_edges(16);
        en  = 1'b0;
        req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 48; c++) begin
            wait_edges(1);
            if (done === 1'b1 || smp_stb === 1'b1) seen = 1'b1;
        end
        rd_chan = 3'd6;
        #1;
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet: done/smp_stb pulse seen=%b want 0", seen);
        end
        vectors++;
        if (adc_chan !== 3'd3 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_hold: adc_chan=%0d valid6=%b want 3/0", adc_chan, rd_valid);
        end
        en       = 1'b1;
        req      = 1'b1;
        req_chan = 3'd6;
        wait_edges(32);
        vectors++;
        if (adc_chan !== 3'd6 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_issue: adc_chan=%0d done=%b want 6/0", adc_chan, done);
        end
        wait_edges(16);
        vectors++;
        if (done !== 1'b0 || smp_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_clean: done=%b smp_stb=%b want 0/0", done, smp_stb);
        end
        wait_edges(16);
        vectors++;
        if (done !== 1'b1 || done_data !== 12'h106 || smp_chan !== 3'd6) begin
            miscompares++;
            $display("FAIL restart_done: done=%b data=%h ch=%0d want 1/106/6", done, done_data, smp_chan);
        end
        req = 1'b0;
        wait_edges(1);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_width: done=%b want 0", done);
        end
    endtask

    task automatic test_empty_mask();
        logic seen;
        apply_reset();
        en   = 1'b1;
        seen = 1'b0;
        for (int f = 0; f < 10; f++) begin
            for (int c = 0; c < 16; c++) begin
                wait_edges(1);
                if (smp_stb === 1'b1 || done === 1'b1) seen = 1'b1;
            end
            vectors++;
            if (adc_chan !== 3'd0) begin
                miscompares++;
                $display("FAIL empty_chan frame%0d: adc_chan=%0d want 0", f, adc_chan);
            end
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_stb: pulse seen=%b want 0", seen);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        chan_mask = 8'h04;
        en        = 1'b1;
        wait_edges(64);
        rd_chan = 3'd2;
        #1;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 12'h102 || adc_chan !== 3'd2) begin
            miscompares++;
            $display("FAIL arst_pre: valid=%b data=%h chan=%0d want 1/102/2", rd_valid, rd_data, adc_chan);
        end
        wait_edges(7);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (adc_chan !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 12'h000 ||
            smp_chan !== 3'd0 || smp_data !== 12'h000 || smp_stb !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_now: chan=%0d valid=%b data=%h smp_ch=%0d smp_d=%h stb=%b done=%b want all 0",
                     adc_chan, rd_valid, rd_data, smp_chan, smp_data, smp_stb, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_edges(31);
        vectors++;
        if (adc_chan !== 3'd0) begin
            miscompares++;
            $display("FAIL arst_align30: adc_chan=%0d want 0", adc_chan);
        end
        wait_edges(1);
        vectors++;
        if (adc_chan !== 3'd2) begin
            miscompares++;
            $display("FAIL arst_align31: adc_chan=%0d want 2", adc_chan);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_request();
        test_abort();
        test_empty_mask();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
